alu_shift_stage: RTL and testbench



---
 rtl/alu_shift_stage.sv | 125 ++++++++++++
 tb/tb_alu_shift_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_shift_stage.sv
// Post-ALU stage: optional shift/rotate through carry, one bit per clock,
// with the final word and flags held behind a valid/ready handshake.
module alu_shift_stage #(
  parameter int WIDTH = 4,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_r,
  input  logic             in_c,
  input  logic [1:0]       shift_op,
  input  logic [AMT_W-1:0] shift_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_c,
  output logic             out_z,
  output logic             out_n
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_SLL  = 2'b01;
  localparam logic [1:0] OP_SRL  = 2'b10;
  localparam logic [1:0] OP_RRC  = 2'b11;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] work_reg, work_next;
  logic             carry_reg, carry_next;
  logic [AMT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       op_reg, op_next;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      op_reg    <= OP_PASS;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
    end
  end

  // Next-state logic; a pass op or zero amount skips SHIFT entirely
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (shift_op == OP_PASS || shift_amt == '0) state_next = HOLD;
          else                                         state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_reg == AMT_W'(1)) state_next = HOLD;
      end
      HOLD: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load in IDLE, single-bit step per SHIFT cycle, frozen in HOLD
  always_comb begin
    work_next  = work_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          work_next  = in_r;
          carry_next = in_c;
          op_next    = shift_op;
          cnt_next   = shift_amt;
        end
      end
      SHIFT: begin
        cnt_next = cnt_reg - AMT_W'(1);
        case (op_reg)
          OP_SLL: begin
            carry_next = work_reg[WIDTH-1];
            work_next  = {work_reg[WIDTH-2:0], 1'b0};
          end
          OP_SRL: begin
            carry_next = work_reg[0];
            work_next  = {1'b0, work_reg[WIDTH-1:1]};
          end
          OP_RRC: begin
            carry_next = work_reg[0];
            work_next  = {carry_reg, work_reg[WIDTH-1:1]};
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == HOLD);
  end

  assign out_data = work_reg;
  assign out_c    = carry_reg;
  assign out_z    = (work_reg == '0);
  assign out_n    = work_reg[WIDTH-1];

endmodule

// File: tb/tb_alu_shift_stage.sv
// Scoreboard bench for alu_shift_stage: expected results queued at issue,
// compared when out_valid rises, plus backpressure and reset-abort checks.
module tb_alu_shift_stage;

  localparam int WIDTH = 4;
  localparam int AMT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_r = '0;
  logic             in_c = 1'b0;
  logic [1:0]       shift_op = 2'b00;
  logic [AMT_W-1:0] shift_amt = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_c;
  logic             out_z;
  logic             out_n;

  alu_shift_stage #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_c(in_c), .shift_op(shift_op), .shift_amt(shift_amt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_c(out_c), .out_z(out_z), .out_n(out_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       c;
    int         lat;
    int         acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: compare on the first cycle of each out_valid window
  always @(negedge clk) begin
    if (out_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_c", out_c, e.c);
        check("out_z", out_z, (e.data == 4'h0));
        check("out_n", out_n, e.data[3]);
        check("latency", cyc - e.acc_cyc, e.lat);
        done_cnt++;
        $display("txn %0d: data=0x%0h c=%0b z=%0b n=%0b (exp data=0x%0h c=%0b) lat=%0d",
                 done_cnt, out_data, out_c, out_z, out_n, e.data, e.c, cyc - e.acc_cyc);
      end
    end
    prev_valid = out_valid;
  end

  function automatic void model(input logic [3:0] r, input logic c, input logic [1:0] op,
                                input logic [1:0] amt, output logic [3:0] od, output logic oc);
    logic [3:0] w;
    logic       k;
    w = r;
    k = c;
    if (op != 2'b00) begin
      for (int i = 0; i < int'(amt); i++) begin
        case (op)
          2'b01: begin k = w[3]; w = w << 1; end
          2'b10: begin k = w[0]; w = w >> 1; end
          default: begin
            logic nk;
            nk = w[0];
            w = (w >> 1) | (k ? 4'h8 : 4'h0);
            k = nk;
          end
        endcase
      end
    end
    od = w;
    oc = k;
  endfunction

  // Issue one op; returns at the negedge just after the accept edge
  task automatic send(input logic [3:0] r, input logic c, input logic [1:0] op,
                      input logic [1:0] amt, input logic [3:0] ed, input logic ec);
    exp_t e;
    int   k;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    e.data    = ed;
    e.c       = ec;
    e.lat     = (op == 2'b00) ? 0 : int'(amt);
    e.acc_cyc = cyc + 1;
    sb_q.push_back(e);
    in_valid  = 1'b1;
    in_r      = r;
    in_c      = c;
    shift_op  = op;
    shift_amt = amt;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt < target) check("done_timeout", done_cnt, target);
  endtask

  initial begin
    logic [3:0] md;
    logic       mc;
    logic [3:0] rr;
    logic       rc;
    logic [1:0] ro, ra;

    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_c", out_c, 0);
    check("rst_out_z", out_z, 1);
    check("rst_out_n", out_n, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pass ignores a nonzero amount
    send(4'hA, 1'b1, 2'b00, 2'd2, 4'hA, 1'b1);
    wait_done(1);
    send(4'h5, 1'b0, 2'b01, 2'd3, 4'h8, 1'b0);
    wait_done(2);
    send(4'h1, 1'b0, 2'b10, 2'd1, 4'h0, 1'b1);
    wait_done(3);

    // RRC: inspect intermediate word after the first step
    send(4'h3, 1'b0, 2'b11, 2'd2, 4'h8, 1'b1);
    @(negedge clk);
    check("rrc_mid_data", out_data, 4'h1);
    check("rrc_mid_c", out_c, 1);
    check("rrc_mid_valid", out_valid, 0);
    wait_done(4);

    // Backpressure while upstream keeps offering different words
    out_ready = 1'b0;
    send(4'h6, 1'b0, 2'b00, 2'd0, 4'h6, 1'b0);
    wait_done(5);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in_r     = 4'(i + 9);
      in_c     = 1'b1;
      shift_op = 2'b00;
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_data", out_data, 4'h6);
      check("bp_c", out_c, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 0);

    // Reset after the first SLL step aborts the op
    send(4'h5, 1'b0, 2'b01, 2'd3, 4'h8, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_out_z", out_z, 1);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_result", done_cnt, 5);
    send(4'h5, 1'b0, 2'b01, 2'd3, 4'h8, 1'b0);
    wait_done(6);

    // Random ops against the reference model
    for (int i = 0; i < 20; i++) begin
      rr = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      ro = 2'($urandom_range(0, 3));
      ra = 2'($urandom_range(0, 3));
      model(rr, rc, ro, ra, md, mc);
      send(rr, rc, ro, ra, md, mc);
      wait_done(7 + i);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
